// File: rtl/line_sum_accumulator_pkg.sv
// Project-wide image geometry and the width helpers that derive the
// line-sum, accumulator and line-counter widths from it.
package line_sum_accumulator_pkg;

  localparam int DEF_PIXEL_SIZE   = 8;
  localparam int DEF_LINE_SIZE    = 640;
  localparam int DEF_NUM_OF_LINES = 480;

  function automatic int calc_lsw(input int line_size, input int pixel_size);
    return $clog2(line_size) + 2 * pixel_size;
  endfunction

  // Headroom of clog2(lines) bits means a frame of all-max lines cannot overflow.
  function automatic int calc_acw(input int num_lines, input int lsw);
    return $clog2(num_lines) + lsw;
  endfunction

  function automatic int calc_cw(input int num_lines);
    return $clog2(num_lines + 1);
  endfunction

  localparam int DEF_LSW = calc_lsw(DEF_LINE_SIZE, DEF_PIXEL_SIZE);
  localparam int DEF_ACW = calc_acw(DEF_NUM_OF_LINES, DEF_LSW);

endpackage

// File: rtl/line_sum_accumulator_counter.sv
// Free-running 1..N line counter: counts one line per clock, wrapping from
// N back to 1, with flags telling the datapath when a frame starts or ends.
module line_sum_accumulator_counter
  import line_sum_accumulator_pkg::*;
#(
  parameter int N  = DEF_NUM_OF_LINES,
  parameter int CW = calc_cw(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  output logic [CW-1:0] o_cnt,
  output logic          o_wrap,
  output logic          o_completes
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // o_wrap: the count already sits at N, so this edge starts a new frame.
  assign o_wrap      = (r_cnt == CW'(N));
  assign w_cnt_next  = o_wrap ? CW'(1) : r_cnt + CW'(1);
  assign o_completes = (w_cnt_next == CW'(N));
  assign o_cnt       = r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/line_sum_accumulator.sv
// Per-frame accumulator of line sums: adds one line per clock, publishes the
// frame total with a one-cycle frame_done after NUM_OF_LINES lines.
module line_sum_accumulator
  import line_sum_accumulator_pkg::*;
#(
  parameter int PIXEL_SIZE   = DEF_PIXEL_SIZE,
  parameter int LINE_SIZE    = DEF_LINE_SIZE,
  parameter int NUM_OF_LINES = DEF_NUM_OF_LINES,
  localparam int LSW = calc_lsw(LINE_SIZE, PIXEL_SIZE),
  localparam int ACW = calc_acw(NUM_OF_LINES, LSW),
  localparam int CW  = calc_cw(NUM_OF_LINES)
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [LSW-1:0] line_sum,
  output logic [ACW-1:0] Acc_lines_sum,
  output logic [CW-1:0]  line_cnt,
  output logic           frame_done,
  output logic [ACW-1:0] frame_sum
);

  logic [ACW-1:0] r_acc;
  logic           r_done;
  logic [ACW-1:0] r_fsum;

  logic [CW-1:0]  w_cnt;
  logic           w_wrap;
  logic           w_completes;
  logic [ACW-1:0] w_line_ext;
  logic [ACW-1:0] w_acc_next;

  line_sum_accumulator_counter #(
    .N  (NUM_OF_LINES),
    .CW (CW)
  ) u_line_counter (
    .i_clk       (CLK),
    .i_rst_n     (reset),
    .o_cnt       (w_cnt),
    .o_wrap      (w_wrap),
    .o_completes (w_completes)
  );

  assign w_line_ext = ACW'(line_sum);
  // On the wrap edge the incoming line is the first line of the next frame.
  assign w_acc_next = w_wrap ? w_line_ext : r_acc + w_line_ext;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_acc  <= '0;
      r_done <= 1'b0;
      r_fsum <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_done <= w_completes;
      if (w_completes) begin
        r_fsum <= w_acc_next;
      end
    end
  end

  assign Acc_lines_sum = r_acc;
  assign line_cnt      = w_cnt;
  assign frame_done    = r_done;
  assign frame_sum     = r_fsum;

endmodule

// File: tb/tb_line_sum_accumulator.sv
// Scoreboard bench for line_sum_accumulator with an 8-line, 4-pixel geometry:
// the driver queues expected outputs, the monitor compares after each event.
module tb_line_sum_accumulator;

  localparam int PIX   = 8;
  localparam int LSZ   = 4;
  localparam int NL    = 8;
  localparam int LSW   = 18;
  localparam int ACW   = 21;
  localparam int CW    = 4;
  localparam int MAXLS = 262143;

  typedef struct packed {
    logic [ACW-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           done;
    logic [ACW-1:0] fsum;
  } exp_t;

  logic           CLK = 1'b0;
  logic           reset;
  logic [LSW-1:0] line_sum;
  logic [ACW-1:0] Acc_lines_sum;
  logic [CW-1:0]  line_cnt;
  logic           frame_done;
  logic [ACW-1:0] frame_sum;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  line_sum_accumulator #(
    .PIXEL_SIZE   (PIX),
    .LINE_SIZE    (LSZ),
    .NUM_OF_LINES (NL)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .line_sum      (line_sum),
    .Acc_lines_sum (Acc_lines_sum),
    .line_cnt      (line_cnt),
    .frame_done    (frame_done),
    .frame_sum     (frame_sum)
  );

  always #5 CLK = ~CLK;

  function automatic exp_t mk(input int acc, input int cnt, input bit done, input int fs);
    exp_t e;
    e.acc  = acc[ACW-1:0];
    e.cnt  = cnt[CW-1:0];
    e.done = done;
    e.fsum = fs[ACW-1:0];
    return e;
  endfunction

  // Called at a falling edge: drive one line and queue the state expected
  // after the next rising edge, then advance to the following falling edge.
  task automatic cyc(input int ls, input int acc, input int cnt, input bit done, input int fs);
    line_sum = ls[LSW-1:0];
    sb.push_back(mk(acc, cnt, done, fs));
    @(negedge CLK);
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic reset_pulse();
    sb.push_back(mk(0, 0, 1'b0, 0));
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  // Monitor: every rising edge and every reset assertion presents an output.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK or negedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        txn++;
        $display("txn %0d: acc=%0d cnt=%0d done=%0d fsum=%0d (want %0d/%0d/%0d/%0d)",
                 txn, Acc_lines_sum, line_cnt, frame_done, frame_sum,
                 e.acc, e.cnt, e.done, e.fsum);
        checks++;
        if (Acc_lines_sum !== e.acc) begin
          failures++;
          $display("FAIL txn %0d acc: got %0d want %0d", txn, Acc_lines_sum, e.acc);
        end
        checks++;
        if (line_cnt !== e.cnt) begin
          failures++;
          $display("FAIL txn %0d line_cnt: got %0d want %0d", txn, line_cnt, e.cnt);
        end
        checks++;
        if (frame_done !== e.done) begin
          failures++;
          $display("FAIL txn %0d frame_done: got %0d want %0d", txn, frame_done, e.done);
        end
        checks++;
        if (frame_sum !== e.fsum) begin
          failures++;
          $display("FAIL txn %0d frame_sum: got %0d want %0d", txn, frame_sum, e.fsum);
        end
      end
    end
  end

  initial begin : stimulus
    int ls;
    int acc;
    int fs;
    int idx;
    int waited;
    reset    = 1'b1;
    line_sum = '0;
    #1;
    // 1: reset held across three edges with a non-zero input
    sb.push_back(mk(0, 0, 1'b0, 0));
    reset    = 1'b0;
    line_sum = 18'd100;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) cyc(100, 0, 0, 1'b0, 0);

    // 2: release, then 10, 20, 30
    reset = 1'b1;
    cyc(10, 10, 1, 1'b0, 0);
    cyc(20, 30, 2, 1'b0, 0);
    cyc(30, 60, 3, 1'b0, 0);

    // 3: full frame of 5s, then first line of the next frame
    reset_pulse();
    for (int k = 1; k <= NL; k++) cyc(5, 5 * k, k, k == NL, (k == NL) ? 40 : 0);
    cyc(7, 7, 1, 1'b0, 40);
    cyc(3, 10, 2, 1'b0, 40);

    // 4: full frame of maximum line sums, no overflow
    reset_pulse();
    for (int k = 1; k <= NL; k++) cyc(MAXLS, MAXLS * k, k, k == NL, (k == NL) ? 2097144 : 0);
    cyc(0, 0, 1, 1'b0, 2097144);

    // 5: reset mid-frame discards the partial sum
    reset_pulse();
    for (int k = 1; k <= 4; k++) cyc(1, k, k, 1'b0, 0);
    reset_pulse();
    cyc(9, 9, 1, 1'b0, 0);
    for (int k = 2; k <= NL; k++) cyc(0, 9, k, k == NL, (k == NL) ? 9 : 0);

    // 6: three frames of random line sums against a running scoreboard sum
    reset_pulse();
    acc = 0;
    fs  = 0;
    for (int n = 1; n <= 3 * NL; n++) begin
      ls  = int'($urandom_range(255, 0));
      idx = (n - 1) % NL;
      acc = (idx == 0) ? ls : acc + ls;
      if (idx == NL - 1) fs = acc;
      cyc(ls, acc, idx + 1, idx == NL - 1, fs);
    end
    cyc(0, 0, 1, 1'b0, fs);

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_sum_accumulator.md
Name: line_sum_accumulator

Overview:
- Per-frame accumulator of line sums in the image-statistics pipeline.
- Each clock, the upstream line-sum stage presents one line's pixel-product sum; this block adds it to a running total.
- Counts lines and, after NUM_OF_LINES lines, publishes the frame total and restarts for the next frame.
- Feeds downstream frame-level normalisation logic.

Parameters:
- PIXEL_SIZE, 8, bits per pixel.
- LINE_SIZE, 640, pixels per line.
- NUM_OF_LINES, 480, lines per frame.
- LSW (derived, localparam), $clog2(LINE_SIZE)+2*PIXEL_SIZE, line_sum width.
- ACW (derived, localparam), $clog2(NUM_OF_LINES)+LSW, accumulator width.
- CW (derived, localparam), $clog2(NUM_OF_LINES+1), line-counter width.

Ports:
- CLK  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to CLK.
- line_sum  in  LSW  unsigned sum of one line; sampled every rising CLK edge.
- Acc_lines_sum  out  ACW  running unsigned sum of the current frame's lines, registered.
- line_cnt  out  CW  number of lines accumulated in the current frame, 0..NUM_OF_LINES.
- frame_done  out  1  one-cycle pulse; Acc_lines_sum holds a complete frame total.
- frame_sum  out  ACW  last completed frame total; held until the next frame completes.

Behaviour:
- Reset (reset==0, any time, asynchronous):
  - Acc_lines_sum=0, line_cnt=0, frame_done=0, frame_sum=0.
  - Reset mid-frame discards the partial sum; no frame_done is emitted for it.
- No valid strobe: every rising CLK with reset==1 consumes line_sum as one line.
- Normal edge (line_cnt < NUM_OF_LINES):
  - Acc_lines_sum <= Acc_lines_sum + zero-extended line_sum.
  - line_cnt <= line_cnt+1.
- Latency: line_sum sampled at edge k appears in Acc_lines_sum after edge k (one register stage).
- Frame completion: on the edge where line_cnt becomes NUM_OF_LINES:
  - frame_done <= 1.
  - frame_sum <= new accumulated value.
  - Acc_lines_sum shows the full total in the same cycle.
- Wrap edge (line_cnt == NUM_OF_LINES):
  - Acc_lines_sum <= zero-extended line_sum (new frame starts with this line).
  - line_cnt <= 1; frame_done <= 0.
- frame_done is 0 on every edge other than completion edges.
- Width rule: ACW is sized so NUM_OF_LINES lines of max value (2^LSW-1) never overflow. No saturation logic; unsigned arithmetic only.
- All outputs driven directly from flops; no combinational input-to-output path.
- reset released mid-cycle: the first rising edge after release accumulates normally from 0.

Decomposition:
- Shared package (project parameters package) holds PIXEL_SIZE, LINE_SIZE, NUM_OF_LINES and width helpers LSW/ACW.
- Single module; no sub-module needed.
- Optional: factor a generic modulo-N line counter if other blocks reuse it.

Test Plan:
Bench parameters: NUM_OF_LINES=8, LINE_SIZE=4, PIXEL_SIZE=8, giving LSW=18 and ACW=21.
1. Reset held low 3 edges with line_sum=100 -> Acc_lines_sum=0, line_cnt=0, frame_done=0 throughout.
2. Release reset; feed 10,20,30 on consecutive edges -> Acc_lines_sum 10, 30, 60; line_cnt 1, 2, 3.
3. Feed 8 lines of value 5 -> after 8th edge: Acc_lines_sum=40, frame_sum=40, frame_done=1 for exactly one cycle. Next edge with line_sum=7 -> Acc_lines_sum=7, line_cnt=1, frame_done=0, frame_sum still 40.
4. Feed 8 lines of 2^18-1=262143 -> Acc_lines_sum=2097144, no wrap, matches frame_sum.
5. After 4 lines of value 1 (Acc=4), pulse reset low for 1 ns between edges -> outputs zero immediately. Next edge with line_sum=9 -> Acc=9, line_cnt=1; no frame_done for the aborted frame.
6. Random line_sum 0..255 over 3 full frames -> frame_sum equals a scoreboard sum per frame; frame_done pulses at edges 8, 16, 24 after reset release.
